rec_struct_fifo: RTL

//  - Parametrised FIFO of packed records {op[OP_W], pl[PL_W]}.
//  - Extends the single-register struct/union scheme to a DEPTH-deep buffered store.
//  - Uses a valid/ready handshake on both sides; also presents a flattened raw view of the head record.
//  - Sits between record producers (decoders) and record consumers inside one clock domain.

---
 rtl/rec_struct_pkg.sv | 11 +
 rtl/rec_struct_mem.sv | 22 ++
 rtl/rec_struct_fifo.sv | 104 ++++++++++
 3 files changed

// File: rtl/rec_struct_pkg.sv
// rec_struct_pkg: shared record widths and parity helper for the record FIFO.
package rec_struct_pkg;
  localparam int REC_OP_W  = 32;
  localparam int REC_PL_W  = 6;
  localparam int REC_MAX_W = 256;

  // Callers zero-extend narrower records; the extra zeros leave the parity unchanged.
  function automatic logic rec_parity(logic [REC_MAX_W-1:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/rec_struct_mem.sv
// rec_struct_mem: DEPTH x W register array, one write port, one combinational read port.
module rec_struct_mem
  import rec_struct_pkg::*;
#(
  parameter int W     = REC_OP_W + REC_PL_W,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rec_struct_fifo.sv
// rec_struct_fifo: valid/ready FIFO of packed {op,pl} records with level and high-water mark.
// Define REC_FIFO_PARITY_EN to store a parity bit per entry and flag a sticky par_err on pop.
module rec_struct_fifo
  import rec_struct_pkg::*;
#(
  parameter int OP_W  = REC_OP_W,
  parameter int PL_W  = REC_PL_W,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [PL_W-1:0]          in_pl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [PL_W-1:0]          out_pl,
  output logic [OP_W+PL_W-1:0]     out_raw,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   hwm,
  output logic                     par_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = OP_W + PL_W;
`ifdef REC_FIFO_PARITY_EN
  localparam int EW = RW + 1;
`else
  localparam int EW = RW;
`endif

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [PL_W-1:0] pl;
  } rec_t;

  rec_t          wr_rec, rd_rec;
  logic [EW-1:0] wdata, rdata;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, hwm_q, hwm_d;
  logic          push, pop;

  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr_rec    = '{op: in_op, pl: in_pl};

  // DEPTH is a power of two, so plain AW-bit increments wrap DEPTH-1 -> 0.
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    hwm_d    = flush ? '0 : (count_d > hwm_q ? count_d : hwm_q);
  end

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end

`ifdef REC_FIFO_PARITY_EN
  logic par_err_q, par_err_d;
  assign wdata     = {rec_parity(REC_MAX_W'(wr_rec)), wr_rec};
  assign rd_rec    = rdata[RW-1:0];
  assign par_err_d = flush ? 1'b0
                   : par_err_q | (pop & (rec_parity(REC_MAX_W'(rd_rec)) != rdata[RW]));
  assign par_err   = par_err_q;

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
`else
  assign wdata   = wr_rec;
  assign rd_rec  = rdata;
  assign par_err = 1'b0;
`endif

  rec_struct_mem #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i   (clock),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign out_op  = rd_rec.op;
  assign out_pl  = rd_rec.pl;
  assign out_raw = rd_rec;
  assign level   = count_q;
  assign hwm     = hwm_q;
endmodule
